// File: rtl/hwag_cfg_pkg.sv
// rtl/hwag_cfg_pkg.sv - shared types and defaults for the hwag configuration scheduler
package hwag_cfg_pkg;

    localparam int HWAG_ADDR_W  = 8;
    localparam int HWAG_DATA_W  = 16;
    localparam int HWAG_CFG_LEN = 131;

    // The verify-enable flag sits directly above the data field of a table word
    localparam int HWAG_VERIFY_BIT = HWAG_DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERR    = 3'd4
    } cfg_state_t;

    // Verify-enable bit index for an arbitrary data width
    function automatic int verify_bit(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/hwag_cfg_sched.sv
// rtl/hwag_cfg_sched.sv - boot-table loader/verifier sharing the hwag register bus with the host
module hwag_cfg_sched
    import hwag_cfg_pkg::*;
#(
    parameter int ADDR_W    = HWAG_ADDR_W,
    parameter int DATA_W    = HWAG_DATA_W,
    parameter int CFG_LEN   = HWAG_CFG_LEN,
    parameter int AUTO_BOOT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W:0]   tbl_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              boot_done,
    output logic              boot_err,
    output logic [ADDR_W-1:0] err_addr
);

    // Counter is one bit wider than the address so CFG_LEN = 2^ADDR_W ends cleanly
    localparam int                KW       = ADDR_W + 1;
    localparam logic [KW-1:0]     LEN_K    = KW'(CFG_LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CFG_LEN - 1);
    localparam int                VB       = verify_bit(DATA_W);

    cfg_state_t        r_state;
    cfg_state_t        w_state_nxt;
    logic [KW-1:0]     r_k;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_idx;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_rd_idx;
    logic              r_host_pend;
    logic              r_host_we;
    logic [ADDR_W-1:0] r_host_addr;
    logic [DATA_W-1:0] r_host_wdata;
    logic              r_rvalid;
    logic              r_boot_done;
    logic              r_boot_err;
    logic [ADDR_W-1:0] r_err_addr;

    logic w_issue;
    logic w_rd_issue;
    logic w_mismatch;
    logic w_last_ok;
    logic w_host_phase;
    logic w_sample;

    assign w_issue      = ((r_state == ST_LOAD) || (r_state == ST_VERIFY)) && (r_k < LEN_K);
    // A mismatch only counts when the table entry asks for verification
    assign w_mismatch   = r_rd_valid && tbl_data[VB] && (reg_rdata != tbl_data[DATA_W-1:0]);
    assign w_last_ok    = r_rd_valid && (r_rd_idx == LAST_IDX) && !w_mismatch;
    // The read racing the failing compare is suppressed so nothing past the error is touched
    assign w_rd_issue   = (r_state == ST_VERIFY) && w_issue && !w_mismatch;
    assign w_host_phase = (r_state == ST_RUN) || (r_state == ST_ERR);
    // cfg_start beats a fresh host request; a request is only sampled with nothing in flight
    assign w_sample     = w_host_phase && !r_host_pend && host_req && !cfg_start;

    assign host_gnt    = r_host_pend;
    assign host_rvalid = r_rvalid;
    assign host_rdata  = r_rvalid ? reg_rdata : '0;
    assign boot_done   = r_boot_done;
    assign boot_err    = r_boot_err;
    assign err_addr    = r_err_addr;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and register-bus drive (boot write, verify read, then host)
    always_comb begin
        w_state_nxt = r_state;
        tbl_addr    = '0;
        reg_we      = 1'b0;
        reg_re      = 1'b0;
        reg_addr    = '0;
        reg_wdata   = '0;
        case (r_state)
            ST_IDLE: begin
                if ((AUTO_BOOT != 0) || cfg_start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_issue) tbl_addr = r_k[ADDR_W-1:0];
                else         w_state_nxt = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (w_issue) tbl_addr = r_k[ADDR_W-1:0];
                if (w_mismatch)     w_state_nxt = ST_ERR;
                else if (w_last_ok) w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_ERR: begin
                if (cfg_start) w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (r_wr_valid) begin
            reg_we    = 1'b1;
            reg_addr  = r_wr_idx;
            reg_wdata = tbl_data[DATA_W-1:0];
        end else if (w_rd_issue) begin
            reg_re   = 1'b1;
            reg_addr = r_k[ADDR_W-1:0];
        end else if (r_host_pend) begin
            reg_we    = r_host_we;
            reg_re    = !r_host_we;
            reg_addr  = r_host_addr;
            reg_wdata = r_host_we ? r_host_wdata : '0;
        end
    end

    // Table/read pipeline stages, host capture and boot status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k          <= '0;
            r_wr_valid   <= 1'b0;
            r_wr_idx     <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_idx     <= '0;
            r_host_pend  <= 1'b0;
            r_host_we    <= 1'b0;
            r_host_addr  <= '0;
            r_host_wdata <= '0;
            r_rvalid     <= 1'b0;
            r_boot_done  <= 1'b0;
            r_boot_err   <= 1'b0;
            r_err_addr   <= '0;
        end else begin
            r_wr_valid  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rvalid    <= r_host_pend && !r_host_we;
            r_host_pend <= w_sample;
            if (w_sample) begin
                r_host_we    <= host_we;
                r_host_addr  <= host_addr;
                r_host_wdata <= host_wdata;
            end
            case (r_state)
                ST_IDLE: begin
                    r_k <= '0;
                end
                ST_LOAD: begin
                    if (w_issue) begin
                        r_wr_valid <= 1'b1;
                        r_wr_idx   <= r_k[ADDR_W-1:0];
                        r_k        <= r_k + 1'b1;
                    end else begin
                        r_k <= '0;
                    end
                end
                ST_VERIFY: begin
                    if (w_rd_issue) begin
                        r_rd_valid <= 1'b1;
                        r_rd_idx   <= r_k[ADDR_W-1:0];
                        r_k        <= r_k + 1'b1;
                    end
                    if (w_mismatch) begin
                        r_boot_err <= 1'b1;
                        r_err_addr <= r_rd_idx;
                    end else if (w_last_ok) begin
                        r_boot_done <= 1'b1;
                    end
                end
                ST_RUN, ST_ERR: begin
                    if (cfg_start) begin
                        r_k         <= '0;
                        r_boot_done <= 1'b0;
                        r_boot_err  <= 1'b0;
                        r_err_addr  <= '0;
                    end
                end
                default: r_k <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hwag_cfg_sched.sv
// tb/tb_hwag_cfg_sched.sv - scoreboard bench for hwag_cfg_sched
module tb_hwag_cfg_sched;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LEN = 131;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_start = 1'b0;
    logic [AW-1:0] tbl_addr;
    logic [DW:0]   tbl_data;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_we;
    logic          reg_re;
    logic [DW-1:0] reg_rdata;
    logic          boot_done;
    logic          boot_err;
    logic [AW-1:0] err_addr;

    logic [DW:0]      tbl  [256];
    logic [DW-1:0]    regs [256];
    logic             ovr_en = 1'b0;
    logic [AW-1:0]    ovr_addr = '0;
    logic [DW-1:0]    ovr_val = '0;
    logic [AW+DW-1:0] wq [$];
    logic [DW-1:0]    rq [$];
    logic [AW+DW-1:0] exp_w;
    logic [DW-1:0]    exp_r;
    int               n_cmp = 0;
    int               n_err = 0;
    int               max_rd = -1;
    bit               both_seen = 1'b0;
    int               cyc;

    always #5 clk = ~clk;

    hwag_cfg_sched #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .CFG_LEN  (LEN),
        .AUTO_BOOT(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rdata (host_rdata),
        .host_rvalid(host_rvalid),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .boot_done  (boot_done),
        .boot_err   (boot_err),
        .err_addr   (err_addr)
    );

    // Boot-table ROM, one cycle of latency
    always @(posedge clk) tbl_data <= tbl[tbl_addr];

    // hwag register file echoing writes, with an optional readback override
    always @(posedge clk) begin
        if (reg_we) regs[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= (ovr_en && reg_addr == ovr_addr) ? ovr_val : regs[reg_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: pops expected writes and host read data as the DUT produces them
    always @(negedge clk) begin
        if (rst) begin
            if (reg_we && reg_re) both_seen = 1'b1;
            if (reg_re && int'(reg_addr) > max_rd) max_rd = int'(reg_addr);
            if (reg_we) begin
                chk("write_expected", 64'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    exp_w = wq.pop_front();
                    chk("write_addr_data", {reg_addr, reg_wdata}, exp_w);
                end
            end
            if (host_rvalid) begin
                chk("read_expected", 64'(rq.size() > 0), 1);
                if (rq.size() > 0) begin
                    exp_r = rq.pop_front();
                    chk("host_rdata", host_rdata, exp_r);
                end
            end
        end
    end

    task automatic push_boot();
        for (int i = 0; i < LEN; i++) wq.push_back({AW'(i), tbl[i][DW-1:0]});
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); #1;
            n = i;
            if (boot_done) break;
        end
        chk("boot_done_seen", boot_done, 1);
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            n = i;
            if (host_gnt) break;
        end
        chk("host_gnt_seen", host_gnt, 1);
    endtask

    task automatic pulse_start();
        @(negedge clk) cfg_start = 1'b1;
        @(negedge clk) cfg_start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tbl[i]  = {1'b1, 16'd0};
            regs[i] = '0;
        end
        tbl[0]   = {1'b1, 16'd128};
        tbl[4]   = {1'b1, 16'd57};
        tbl[5]   = {1'b1, 16'd4};
        tbl[6]   = {1'b1, 16'd3839};
        tbl[63]  = {1'b1, 16'd7};
        tbl[65]  = {1'b1, 16'd2};
        tbl[70]  = {1'b1, 16'd2};
        tbl[127] = {1'b1, 16'd1024};
        tbl[129] = {1'b1, 16'd3830};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_bus", {tbl_addr, reg_addr, reg_wdata, reg_we, reg_re}, 0);
        chk("reset_outs_status", {host_gnt, host_rdata, host_rvalid, boot_done, boot_err, err_addr}, 0);

        // Auto boot: cycles counted from the first clock edge after release
        push_boot();
        @(negedge clk) rst = 1'b1;
        wait_done(cyc);
        chk("boot_latency", 64'(cyc - 1), 2 * LEN + 2);
        chk("boot_writes_drained", 64'(wq.size()), 0);
        chk("boot_err_clean", boot_err, 0);

        // Host write in RUN: grant one cycle after sampling, coincident with reg_we
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'd200; host_wdata = 16'hBEEF;
        wq.push_back({8'd200, 16'hBEEF});
        wait_gnt(cyc);
        chk("host_gnt_latency", 64'(cyc), 1);
        chk("host_write_strobe", {reg_we, reg_re}, 2'b10);
        host_req = 1'b0;
        @(negedge clk);
        chk("host_write_drained", 64'(wq.size()), 0);

        // Host read in RUN
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'd4;
        rq.push_back(16'd57);
        wait_gnt(cyc);
        chk("host_read_strobe", {reg_we, reg_re}, 2'b01);
        host_req = 1'b0;
        @(negedge clk);
        chk("host_rvalid_follow", host_rvalid, 1);
        @(negedge clk);
        chk("host_read_drained", 64'(rq.size()), 0);

        // Corrupted readback at 70
        ovr_en = 1'b1; ovr_addr = 8'd70; ovr_val = 16'd3; max_rd = -1;
        push_boot();
        pulse_start();
        chk("restart_clears_done", boot_done, 0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (boot_err) break;
        end
        chk("boot_err_set", boot_err, 1);
        chk("err_addr", err_addr, 70);
        chk("err_writes_drained", 64'(wq.size()), 0);
        repeat (20) @(negedge clk);
        chk("no_read_past_err", 64'(max_rd), 70);
        chk("err_no_done", boot_done, 0);

        // Host read still served in ERR
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'd70;
        rq.push_back(16'd3);
        wait_gnt(cyc);
        host_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("err_read_drained", 64'(rq.size()), 0);

        // Verify disabled at 63 while the model returns 0 there
        tbl[63] = {1'b0, 16'd7};
        ovr_addr = 8'd63; ovr_val = 16'd0;
        push_boot();
        pulse_start();
        chk("restart_clears_err", {boot_err, err_addr}, 0);
        wait_done(cyc);
        chk("skip_verify_no_err", boot_err, 0);
        chk("skip_writes_drained", 64'(wq.size()), 0);

        // Host request held through a boot
        push_boot();
        pulse_start();
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'd129;
        rq.push_back(16'd3830);
        wait_gnt(cyc);
        chk("held_gnt_after_boot", boot_done, 1);
        host_req = 1'b0;
        @(negedge clk);
        chk("held_rvalid_follow", host_rvalid, 1);
        @(negedge clk);
        chk("held_read_drained", 64'(rq.size()), 0);
        chk("held_writes_drained", 64'(wq.size()), 0);

        // cfg_start and host_req together in RUN: the boot wins
        push_boot();
        @(negedge clk);
        cfg_start = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'd5;
        rq.push_back(16'd4);
        @(negedge clk);
        cfg_start = 1'b0;
        chk("sim_done_cleared", boot_done, 0);
        chk("sim_no_gnt", host_gnt, 0);
        wait_gnt(cyc);
        chk("sim_gnt_after_boot", boot_done, 1);
        host_req = 1'b0;
        @(negedge clk);
        chk("sim_rvalid_follow", host_rvalid, 1);
        @(negedge clk);
        chk("sim_read_drained", 64'(rq.size()), 0);

        // Reset during VERIFY at k=50
        push_boot();
        pulse_start();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (reg_re && reg_addr == 8'd50) break;
        end
        chk("reached_verify_50", {reg_re, reg_addr}, {1'b1, 8'd50});
        chk("pre_reset_writes_drained", 64'(wq.size()), 0);
        rst = 1'b0;
        #1;
        chk("midrst_outs_bus", {tbl_addr, reg_addr, reg_wdata, reg_we, reg_re}, 0);
        chk("midrst_outs_status", {host_gnt, host_rdata, host_rvalid, boot_done, boot_err, err_addr}, 0);
        wq.delete();
        rq.delete();
        push_boot();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("fresh_load_first_write", {reg_we, reg_addr, tbl_addr}, {1'b1, 8'd0, 8'd1});
        wait_done(cyc);
        chk("fresh_boot_latency", 64'(cyc + 1), 2 * LEN + 2);
        chk("fresh_writes_drained", 64'(wq.size()), 0);
        chk("never_we_and_re", 64'(both_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
